// File: rtl/scoreboarded_register_file.sv
// Two-read/one-write register file with busy scoreboard and sequenced bulk clear.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module scoreboarded_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic [ADDR_WIDTH-1:0]            readAddressA,
  input  logic [ADDR_WIDTH-1:0]            readAddressB,
  output logic [DATA_WIDTH-1:0]            readDataA,
  output logic [DATA_WIDTH-1:0]            readDataB,
  output logic                             readBusyA,
  output logic                             readBusyB,
  input  logic                             reserveEnabled,
  input  logic [ADDR_WIDTH-1:0]            reserveAddress,
  input  logic                             writeEnabled,
  input  logic [ADDR_WIDTH-1:0]            writeAddress,
  input  logic [DATA_WIDTH-1:0]            writeData,
  input  logic                             clearRequest,
  output logic                             clearBusy,
  output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0] debug_registers,
  output logic [(1<<ADDR_WIDTH)-1:0]       debug_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEARING} state_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                 regs_q [DEPTH];
  word_t                 regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic idle;
  logic wr_ok;
  logic rsv_ok;

  assign idle   = (state_q == IDLE);
  assign wr_ok  = idle && writeEnabled
                  && !(ZERO_REG && writeAddress == '0);
  assign rsv_ok = idle && reserveEnabled
                  && !(ZERO_REG && reserveAddress == '0);

  // Reserve applied after write so a same-edge collision leaves busy set.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wr_ok) begin
          regs_d[writeAddress] = writeData;
          busy_d[writeAddress] = 1'b0;
        end
        if (rsv_ok) begin
          busy_d[reserveAddress] = 1'b1;
        end
        if (clearRequest) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    readDataA = regs_q[readAddressA];
    readBusyA = busy_q[readAddressA];
    if (ZERO_REG && readAddressA == '0) begin
      readDataA = '0;
      readBusyA = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && writeAddress == readAddressA) begin
      readDataA = writeData;
      readBusyA = 1'b0;
    end
`endif
  end

  always_comb begin
    readDataB = regs_q[readAddressB];
    readBusyB = busy_q[readAddressB];
    if (ZERO_REG && readAddressB == '0) begin
      readDataB = '0;
      readBusyB = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && writeAddress == readAddressB) begin
      readDataB = writeData;
      readBusyB = 1'b0;
    end
`endif
  end

  assign clearBusy  = (state_q == CLEARING);
  assign debug_busy = busy_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
    assign debug_registers[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Directed self-checking bench for scoreboarded_register_file.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_scoreboarded_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic              clock = 1'b0;
  logic              resetN;
  logic [AW-1:0]     readAddressA, readAddressB;
  logic [DW-1:0]     readDataA, readDataB;
  logic              readBusyA, readBusyB;
  logic              reserveEnabled;
  logic [AW-1:0]     reserveAddress;
  logic              writeEnabled;
  logic [AW-1:0]     writeAddress;
  logic [DW-1:0]     writeData;
  logic              clearRequest;
  logic              clearBusy;
  logic [DEPTH*DW-1:0] debug_registers;
  logic [DEPTH-1:0]  debug_busy;

  int n_checks = 0;
  int n_fail   = 0;

  scoreboarded_register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ZERO_REG  (1'b1)
  ) dut (
    .clock          (clock),
    .resetN         (resetN),
    .readAddressA   (readAddressA),
    .readAddressB   (readAddressB),
    .readDataA      (readDataA),
    .readDataB      (readDataB),
    .readBusyA      (readBusyA),
    .readBusyB      (readBusyB),
    .reserveEnabled (reserveEnabled),
    .reserveAddress (reserveAddress),
    .writeEnabled   (writeEnabled),
    .writeAddress   (writeAddress),
    .writeData      (writeData),
    .clearRequest   (clearRequest),
    .clearBusy      (clearBusy),
    .debug_registers(debug_registers),
    .debug_busy     (debug_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return debug_registers[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] val(input int i);
    return 32'hC000_0000 | (i * 32'h0101);
  endfunction

  task automatic idle_inputs();
    writeEnabled   = 1'b0;
    reserveEnabled = 1'b0;
    clearRequest   = 1'b0;
  endtask

  initial begin
    int j;
    int hi;
    resetN         = 1'b0;
    readAddressA   = '0;
    readAddressB   = '0;
    reserveAddress = '0;
    writeAddress   = '0;
    writeData      = '0;
    idle_inputs();
    repeat (2) tick();
    check("rst_regs", 64'(|debug_registers), 0);
    check("rst_busy", 64'(debug_busy), 0);
    check("rst_clrbusy", 64'(clearBusy), 0);
    resetN = 1'b1;
    tick();

    // r5 write, visible next cycle
    writeEnabled = 1'b1; writeAddress = 5; writeData = 32'hDEADBEEF;
    tick();
    idle_inputs();
    readAddressA = 5;
    #1 check("wr_r5", readDataA, 32'hDEADBEEF);

    // r0 write and reserve ignored
    writeEnabled = 1'b1; writeAddress = 0; writeData = 32'h1234;
    reserveEnabled = 1'b1; reserveAddress = 0;
    tick();
    idle_inputs();
    readAddressA = 0;
    #1 check("r0_data", readDataA, 0);
    check("r0_dbg", rd(0), 0);
    check("r0_busy", 64'(debug_busy[0]), 0);

    // Reserve / collide / release on r7
    reserveEnabled = 1'b1; reserveAddress = 7;
    tick();
    idle_inputs();
    readAddressB = 7;
    #1 check("rsv_r7", 64'(readBusyB), 1);
    writeEnabled = 1'b1; writeAddress = 7; writeData = 32'h55;
    reserveEnabled = 1'b1; reserveAddress = 7;
    tick();
    idle_inputs();
    check("coll_data", readDataB, 32'h55);
    check("coll_busy", 64'(readBusyB), 1);
    writeEnabled = 1'b1; writeAddress = 7; writeData = 32'h66;
    tick();
    idle_inputs();
    check("rel_data", readDataB, 32'h66);
    check("rel_busy", 64'(readBusyB), 0);

    // Bypass behaviour on r3 (reserved first)
    reserveEnabled = 1'b1; reserveAddress = 3;
    tick();
    idle_inputs();
    readAddressA = 3;
    writeEnabled = 1'b1; writeAddress = 3; writeData = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", readDataA, 32'hA5A5A5A5);
    check("byp_busy", 64'(readBusyA), 0);
`else
    check("nobyp_data", readDataA, 0);
    check("nobyp_busy", 64'(readBusyA), 1);
`endif
    tick();
    idle_inputs();
    check("post_wr3", readDataA, 32'hA5A5A5A5);
    check("post_busy3", 64'(readBusyA), 0);

    // Fill every register and reserve it on the same edge
    for (int i = 0; i < DEPTH; i++) begin
      writeEnabled = 1'b1; writeAddress = AW'(i); writeData = val(i);
      reserveEnabled = 1'b1; reserveAddress = AW'(i);
      tick();
    end
    idle_inputs();
    check("fill_busy", 64'(debug_busy), 64'hFFFF_FFFE);
    check("fill_r31", rd(31), val(31));

    // Bulk clear with junk traffic in flight
    clearRequest = 1'b1;
    tick();
    clearRequest = 1'b0;
    readAddressA = 31;
    j  = 0;
    hi = 0;
    while (clearBusy && j < 100) begin
      hi++;
      if (j >= 1) check($sformatf("clr_z%0d", j - 1), rd(j - 1), 0);
      if (j >= 1 && j < DEPTH) check($sformatf("clr_k%0d", j), rd(j), val(j));
      if (j == 15) check("clr_rdA", readDataA, val(31));
      if (j < 20) begin
        writeEnabled = 1'b1; writeAddress = 31; writeData = 32'hBAD;
        reserveEnabled = 1'b1; reserveAddress = 1;
        clearRequest = (j >= 5 && j < 10);
      end else begin
        idle_inputs();
      end
      tick();
      j++;
    end
    idle_inputs();
    check("clr_cycles", 64'(hi), 64'(DEPTH));
    check("clr_regs", 64'(|debug_registers), 0);
    check("clr_busy", 64'(debug_busy), 0);
    tick();
    check("clr_no_restart", 64'(clearBusy), 0);

    // Reset in the middle of a clear
    writeEnabled = 1'b1; writeAddress = 9; writeData = 32'h99;
    tick();
    idle_inputs();
    check("pre_r9", rd(9), 32'h99);
    writeEnabled = 1'b1; writeAddress = 20; writeData = 32'h20;
    tick();
    idle_inputs();
    clearRequest = 1'b1;
    tick();
    clearRequest = 1'b0;
    repeat (10) tick();
    check("mid_clr_r20", rd(20), 32'h20);
    #2 resetN = 1'b0;
    #1;
    check("abort_clrbusy", 64'(clearBusy), 0);
    check("abort_regs", 64'(|debug_registers), 0);
    check("abort_busy", 64'(debug_busy), 0);
    tick();
    resetN = 1'b1;
    writeEnabled = 1'b1; writeAddress = 4; writeData = 32'h44;
    tick();
    idle_inputs();
    check("post_rst_r4", rd(4), 32'h44);
    check("post_rst_idle", 64'(clearBusy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
